// File: rtl/branch_target_buffer_if.sv
// Fetch-lookup / execute-training bundle for the branch target buffer.
interface branch_target_buffer_if;
    logic [63:0] PCF;
    logic [63:0] PCE;
    logic [63:0] PCTargetE;
    logic        UpdateE;
    logic        TakenE;
    logic        JumpE;
    logic        HitF;
    logic        PredTakenF;
    logic [63:0] PredTargetF;
    logic [63:0] PredPCNextF;

    // Pipeline side: drives fetch PC and execute resolution, consumes prediction.
    modport master (
        output PCF, PCE, PCTargetE, UpdateE, TakenE, JumpE,
        input  HitF, PredTakenF, PredTargetF, PredPCNextF
    );

    // BTB side.
    modport slave (
        input  PCF, PCE, PCTargetE, UpdateE, TakenE, JumpE,
        output HitF, PredTakenF, PredTargetF, PredPCNextF
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational from the array state; training happens on the clock edge.
// Optional macro BTB_BYPASS_EN forwards a same-cycle update of the exact fetch PC
// into the lookup outputs.
module branch_target_buffer #(
    parameter int unsigned ENTRIES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    branch_target_buffer_if.slave  btb
);
    localparam int unsigned INDEX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W   = 64 - INDEX_W - 2;

    logic [ENTRIES-1:0] validQ;
    logic [TAG_W-1:0]   tagQ    [ENTRIES];
    logic [63:0]        targetQ [ENTRIES];
    logic [1:0]         ctrQ    [ENTRIES];

    logic [INDEX_W-1:0] updIdx;
    logic [TAG_W-1:0]   updTag;
    logic               updHit;
    logic               effTaken;
    logic               writeEn;
    logic [1:0]         newCtr;

    logic [INDEX_W-1:0] lkIdx;
    logic [TAG_W-1:0]   lkTag;
    logic               lkHit;
    logic [1:0]         lkCtr;
    logic [63:0]        lkTarget;

    // PCs are word aligned; the low two bits carry no information.
    logic unusedPcBits;
    assign unusedPcBits = ^{btb.PCE[1:0], btb.PCF[1:0]};

    // Training decision: hit/allocate and the counter value to write.
    always_comb begin
        updIdx   = btb.PCE[INDEX_W+1:2];
        updTag   = btb.PCE[63:INDEX_W+2];
        updHit   = validQ[updIdx] && (tagQ[updIdx] == updTag);
        effTaken = btb.JumpE | btb.TakenE;
        // Not-taken branches that miss are never allocated; reset discards updates.
        writeEn  = btb.UpdateE && !rst && (updHit || effTaken);
        newCtr   = 2'b10;
        if (btb.JumpE) begin
            newCtr = 2'b11;
        end else if (updHit) begin
            if (effTaken) begin
                newCtr = (ctrQ[updIdx] == 2'b11) ? 2'b11 : ctrQ[updIdx] + 2'd1;
            end else begin
                newCtr = (ctrQ[updIdx] == 2'b00) ? 2'b00 : ctrQ[updIdx] - 2'd1;
            end
        end
    end

    // Entry array: valid bits reset, payload written only on a training write.
    always_ff @(posedge clk) begin
        if (rst) begin
            validQ <= '0;
        end else if (writeEn) begin
            validQ[updIdx]  <= 1'b1;
            tagQ[updIdx]    <= updTag;
            targetQ[updIdx] <= btb.PCTargetE;
            ctrQ[updIdx]    <= newCtr;
        end
    end

    // Fetch lookup and next-PC selection.
    always_comb begin
        lkIdx    = btb.PCF[INDEX_W+1:2];
        lkTag    = btb.PCF[63:INDEX_W+2];
        lkHit    = validQ[lkIdx] && (tagQ[lkIdx] == lkTag);
        lkCtr    = ctrQ[lkIdx];
        lkTarget = targetQ[lkIdx];
`ifdef BTB_BYPASS_EN
        // Only an update of the very same PC that actually writes is forwarded.
        if (writeEn && (btb.PCE[63:2] == btb.PCF[63:2])) begin
            lkHit    = 1'b1;
            lkCtr    = newCtr;
            lkTarget = btb.PCTargetE;
        end
`endif
        // Valid bits still hold pre-reset contents during the reset cycle itself.
        if (rst) begin
            lkHit = 1'b0;
        end
        btb.HitF        = lkHit;
        btb.PredTakenF  = lkHit && lkCtr[1];
        btb.PredTargetF = lkHit ? lkTarget : 64'd0;
        btb.PredPCNextF = (lkHit && lkCtr[1]) ? lkTarget : btb.PCF + 64'd4;
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed vector table followed by
// randomized traffic checked against a behavioural model of the prediction rules.
module tb_branch_target_buffer;
    localparam int unsigned ENTRIES = 16;
    localparam int unsigned INDEX_W = 4;

    logic clk;
    logic rst;
    int   passCnt;
    int   totalCnt;

    branch_target_buffer_if bus();

    branch_target_buffer #(.ENTRIES(ENTRIES)) dut (
        .clk (clk),
        .rst (rst),
        .btb (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          upd;
        bit          taken;
        bit          jump;
        logic [63:0] pcf;
        logic [63:0] pce;
        logic [63:0] tgt;
        bit          expHit;
        bit          expTaken;
        logic [63:0] expTarget;
        logic [63:0] expNext;
    } vec_t;

    // Reference state: one record per slot, addressed by plain arithmetic on the PC.
    bit              mValid [ENTRIES];
    longint unsigned mTag   [ENTRIES];
    longint unsigned mTgt   [ENTRIES];
    int              mCtr   [ENTRIES];

    function automatic int idxOf(input longint unsigned pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic longint unsigned tagOf(input longint unsigned pc);
        return pc >> (2 + INDEX_W);
    endfunction

    // What a training event would do to its slot: does it write, and with which counter.
    function automatic void modelUpdate(input bit taken, input bit jump,
                                        input longint unsigned pce,
                                        output bit writes, output int ctr);
        int i;
        bit hit;
        bit t;
        i      = idxOf(pce);
        hit    = mValid[i] && (mTag[i] == tagOf(pce));
        t      = taken || jump;
        writes = hit || t;
        if (jump)     ctr = 3;
        else if (hit) ctr = t ? ((mCtr[i] < 3) ? mCtr[i] + 1 : 3)
                              : ((mCtr[i] > 0) ? mCtr[i] - 1 : 0);
        else          ctr = 2;
    endfunction

    function automatic void modelPredict(input vec_t v, output bit hit, output bit tk,
                                         output longint unsigned target,
                                         output longint unsigned nxt);
        int i;
        int ctr;
`ifdef BTB_BYPASS_EN
        bit w;
        int nc;
`endif
        i      = idxOf(v.pcf);
        hit    = mValid[i] && (mTag[i] == tagOf(v.pcf));
        ctr    = mCtr[i];
        target = mTgt[i];
`ifdef BTB_BYPASS_EN
        if (v.upd && !v.rst && ((v.pce >> 2) == (v.pcf >> 2))) begin
            modelUpdate(v.taken, v.jump, v.pce, w, nc);
            if (w) begin
                hit    = 1'b1;
                ctr    = nc;
                target = v.tgt;
            end
        end
`endif
        if (v.rst) hit = 1'b0;
        tk     = hit && (ctr >= 2);
        if (!hit) target = 64'd0;
        nxt    = tk ? target : v.pcf + 64'd4;
    endfunction

    function automatic void modelCommit(input vec_t v);
        bit w;
        int nc;
        int i;
        if (v.rst) begin
            for (int k = 0; k < int'(ENTRIES); k++) mValid[k] = 1'b0;
        end else if (v.upd) begin
            modelUpdate(v.taken, v.jump, v.pce, w, nc);
            if (w) begin
                i         = idxOf(v.pce);
                mValid[i] = 1'b1;
                mTag[i]   = tagOf(v.pce);
                mTgt[i]   = v.tgt;
                mCtr[i]   = nc;
            end
        end
    endfunction

    function automatic vec_t mk(input bit r, input logic [63:0] pcf, input bit upd,
                                input logic [63:0] pce, input logic [63:0] tgt,
                                input bit taken, input bit jump,
                                input bit eh, input bit et,
                                input logic [63:0] etgt, input logic [63:0] enext);
        vec_t v;
        v.rst = r;  v.pcf = pcf; v.upd = upd; v.pce = pce; v.tgt = tgt;
        v.taken = taken; v.jump = jump;
        v.expHit = eh; v.expTaken = et; v.expTarget = etgt; v.expNext = enext;
        return v;
    endfunction

    // One cycle: drive, sample at the falling edge, then let the edge train the model.
    task automatic step(input vec_t v, input bit useTable, input string name);
        bit              eHit;
        bit              eTk;
        longint unsigned eTgt;
        longint unsigned eNext;
        rst           = v.rst;
        bus.PCF       = v.pcf;
        bus.PCE       = v.pce;
        bus.PCTargetE = v.tgt;
        bus.UpdateE   = v.upd;
        bus.TakenE    = v.taken;
        bus.JumpE     = v.jump;
        @(negedge clk);
        if (useTable) begin
            eHit = v.expHit; eTk = v.expTaken; eTgt = v.expTarget; eNext = v.expNext;
        end else begin
            modelPredict(v, eHit, eTk, eTgt, eNext);
        end
        totalCnt++;
        if (bus.HitF === eHit && bus.PredTakenF === eTk &&
            bus.PredTargetF === eTgt && bus.PredPCNextF === eNext) begin
            passCnt++;
        end else begin
            $display("FAIL %s pcf=%h: got hit=%0b taken=%0b target=%h next=%h, want hit=%0b taken=%0b target=%h next=%h",
                     name, v.pcf, bus.HitF, bus.PredTakenF, bus.PredTargetF, bus.PredPCNextF,
                     eHit, eTk, eTgt, eNext);
        end
        @(posedge clk);
        modelCommit(v);
        #1;
    endtask

    function automatic logic [63:0] randPc();
        if ($urandom_range(0, 9) == 0)
            return 64'hFFFF_FFFF_FFFF_FFC0 + 64'($urandom_range(0, 15)) * 64'd4;
        return 64'h1000 + 64'($urandom_range(0, 39)) * 64'd4;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t v;
        passCnt  = 0;
        totalCnt = 0;
        for (int k = 0; k < int'(ENTRIES); k++) begin
            mValid[k] = 1'b0; mTag[k] = 0; mTgt[k] = 0; mCtr[k] = 0;
        end

        // Reset, then first allocation of a taken branch.
        tbl.push_back(mk(1, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 0, 0, 64'h0,    64'h1004));
        tbl.push_back(mk(1, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 0, 0, 64'h0,    64'h1004));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 0, 0, 64'h0,    64'h1004));
        tbl.push_back(mk(0, 64'h2000, 1, 64'h1000, 64'h2000, 1, 0, 0, 0, 64'h0,    64'h2004));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h2000, 64'h2000));
        // Counter walks down to 00 and back up with hysteresis.
        tbl.push_back(mk(0, 64'h0,    1, 64'h1000, 64'h2000, 0, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 1, 0, 64'h2000, 64'h1004));
        tbl.push_back(mk(0, 64'h0,    1, 64'h1000, 64'h2000, 0, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h0,    1, 64'h1000, 64'h2000, 0, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 1, 0, 64'h2000, 64'h1004));
        tbl.push_back(mk(0, 64'h0,    1, 64'h1000, 64'h2000, 1, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 1, 0, 64'h2000, 64'h1004));
        tbl.push_back(mk(0, 64'h0,    1, 64'h1000, 64'h2000, 1, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h2000, 64'h2000));
        // Aliasing at index 0 replaces the older tag.
        tbl.push_back(mk(0, 64'h0,    1, 64'h1040, 64'h3000, 1, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 0, 0, 64'h0,    64'h1004));
        tbl.push_back(mk(0, 64'h1040, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h3000, 64'h3000));
        // Not-taken miss is not allocated and leaves the resident entry alone.
        tbl.push_back(mk(0, 64'h0,    1, 64'h1100, 64'h4000, 0, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1100, 0, 64'h0,    64'h0,    0, 0, 0, 0, 64'h0,    64'h1104));
        tbl.push_back(mk(0, 64'h1040, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h3000, 64'h3000));
        // Jump allocates strongly taken; one not-taken still predicts taken.
        tbl.push_back(mk(0, 64'h0,    1, 64'h1200, 64'h1180, 0, 1, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1200, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h1180, 64'h1180));
        tbl.push_back(mk(0, 64'h0,    1, 64'h1200, 64'h1180, 0, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1200, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h1180, 64'h1180));
        // Reset mid-operation discards the concurrent update.
        tbl.push_back(mk(0, 64'h0,    1, 64'h1000, 64'h2000, 1, 0, 0, 0, 64'h0,    64'h4));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h2000, 64'h2000));
        tbl.push_back(mk(1, 64'h1000, 1, 64'h1200, 64'h1180, 1, 0, 0, 0, 64'h0,    64'h1004));
        tbl.push_back(mk(0, 64'h1000, 0, 64'h0,    64'h0,    0, 0, 0, 0, 64'h0,    64'h1004));
        tbl.push_back(mk(0, 64'h1200, 0, 64'h0,    64'h0,    0, 0, 0, 0, 64'h0,    64'h1204));
        // Same-cycle update and lookup of one PC.
`ifdef BTB_BYPASS_EN
        tbl.push_back(mk(0, 64'h1300, 1, 64'h1300, 64'h5000, 1, 0, 1, 1, 64'h5000, 64'h5000));
`else
        tbl.push_back(mk(0, 64'h1300, 1, 64'h1300, 64'h5000, 1, 0, 0, 0, 64'h0,    64'h1304));
`endif
        tbl.push_back(mk(0, 64'h1300, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h5000, 64'h5000));
        // Same index, different tag: lookup sees the old entry that cycle.
        tbl.push_back(mk(0, 64'h1300, 1, 64'h1040, 64'h6000, 1, 0, 1, 1, 64'h5000, 64'h5000));
        tbl.push_back(mk(0, 64'h1300, 0, 64'h0,    64'h0,    0, 0, 0, 0, 64'h0,    64'h1304));
        tbl.push_back(mk(0, 64'h1040, 0, 64'h0,    64'h0,    0, 0, 1, 1, 64'h6000, 64'h6000));
        // Next-PC wraps at the top of the address space.
        tbl.push_back(mk(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 64'h0, 0, 0, 0, 0, 64'h0, 64'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], 1'b1, $sformatf("vec%0d", i));
        end

        // Randomized traffic against the behavioural model.
        for (int i = 0; i < 600; i++) begin
            v.rst   = ($urandom_range(0, 59) == 0);
            v.pcf   = randPc();
            v.pce   = ($urandom_range(0, 3) == 0) ? v.pcf : randPc();
            v.tgt   = {32'($urandom), 30'($urandom), 2'b00};
            v.upd   = ($urandom_range(0, 1) == 1);
            v.taken = ($urandom_range(0, 2) != 0);
            v.jump  = ($urandom_range(0, 5) == 0);
            v.expHit = 1'b0; v.expTaken = 1'b0; v.expTarget = 64'h0; v.expNext = 64'h0;
            step(v, 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
